// File: rtl/flopoco_4_4_pkg.sv
// Shared definitions for the FloPoCo wE=4/wF=4 float format:
// field layout, exception codes and the converter FSM state type.
package flopoco_4_4_pkg;

    localparam int WE   = 4;
    localparam int WF   = 4;
    localparam int FP_W = 11;
    localparam int BIAS = 7;

    localparam logic [1:0] EXN_ZERO   = 2'b00;
    localparam logic [1:0] EXN_NORMAL = 2'b01;
    localparam logic [1:0] EXN_INF    = 2'b10;
    localparam logic [1:0] EXN_NAN    = 2'b11;

    localparam int EXN_HI   = 10;
    localparam int EXN_LO   = 9;
    localparam int SIGN_POS = 8;
    localparam int EXP_HI   = 7;
    localparam int EXP_LO   = 4;
    localparam int FRAC_HI  = 3;
    localparam int FRAC_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/flopoco_unpack_4_4.sv
// Combinational field split of a FloPoCo 4/4 word: exception, sign,
// mantissa with implicit one, and the signed shift toward the fixed-point grid.
module flopoco_unpack_4_4
    import flopoco_4_4_pkg::*;
#(
    parameter int FRAC_W = 4
) (
    input  logic [FP_W-1:0] x,
    output logic [1:0]      exn,
    output logic            sign,
    output logic [WF:0]     mant,
    output logic [4:0]      shamt,
    output logic            shift_left
);

    logic signed [6:0] shift_s;

    assign exn  = x[EXN_HI:EXN_LO];
    assign sign = x[SIGN_POS];
    assign mant = {1'b1, x[FRAC_HI:FRAC_LO]};

    // Value = mant * 2^(E - BIAS - WF); scaling by 2^FRAC_W gives the shift.
    assign shift_s    = $signed({3'b000, x[EXP_HI:EXP_LO]}) - $signed(7'(BIAS + WF - FRAC_W));
    assign shamt      = shift_s[6] ? 5'(-shift_s) : 5'(shift_s);
    assign shift_left = ~shift_s[6];

endmodule

// File: rtl/flopoco_fp_to_fix_4_4.sv
// FloPoCo 4/4 float to signed fixed-point converter with a bit-serial
// shifter (one position per cycle) and valid/ready handshakes on both sides.
module flopoco_fp_to_fix_4_4
    import flopoco_4_4_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  X,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] R,
    output logic             ovf,
    output logic             nan
);

    state_t           state_r, state_nxt_s;
    logic [OUT_W-1:0] mag_r;
    logic [4:0]       cnt_r;
    logic             left_r, sign_r, sov_r;
    logic [1:0]       exn_r;
    logic [OUT_W-1:0] r_r, fin_r_s;
    logic             ovf_r, nan_r, fin_ovf_s, fin_nan_s;
    logic             out_valid_r, in_ready_r;
    logic             accept_s, min_neg_s;

    logic [1:0]       u_exn_s;
    logic             u_sign_s, u_left_s;
    logic [WF:0]      u_mant_s;
    logic [4:0]       u_shamt_s;

    flopoco_unpack_4_4 #(.FRAC_W(FRAC_W)) u_unpack (
        .x          (X),
        .exn        (u_exn_s),
        .sign       (u_sign_s),
        .mant       (u_mant_s),
        .shamt      (u_shamt_s),
        .shift_left (u_left_s)
    );

    function automatic logic [OUT_W-1:0] sat_value(input logic neg);
        sat_value = neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    assign accept_s  = in_valid & in_ready_r & (state_r == ST_IDLE);
    assign min_neg_s = (mag_r == {1'b1, {(OUT_W-1){1'b0}}});

    // Next-state logic of the conversion FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if ((u_exn_s == EXN_NORMAL) && (u_shamt_s != 5'd0)) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_FIN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r <= 5'd1) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_FIN:  state_nxt_s = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Final result selection; the most negative value is the one in-range MSB-set magnitude.
    always_comb begin
        fin_r_s   = {OUT_W{1'b0}};
        fin_ovf_s = 1'b0;
        fin_nan_s = 1'b0;
        case (exn_r)
            EXN_ZERO: fin_r_s = {OUT_W{1'b0}};
            EXN_NAN:  fin_nan_s = 1'b1;
            EXN_INF: begin
                fin_r_s   = sat_value(sign_r);
                fin_ovf_s = 1'b1;
            end
            EXN_NORMAL: begin
                if (sov_r || (mag_r[OUT_W-1] && !(sign_r && min_neg_s))) begin
                    fin_r_s   = sat_value(sign_r);
                    fin_ovf_s = 1'b1;
                end else begin
                    fin_r_s = sign_r ? -mag_r : mag_r;
                end
            end
            default: fin_r_s = {OUT_W{1'b0}};
        endcase
    end

    // State register, serial shifter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            mag_r       <= {OUT_W{1'b0}};
            cnt_r       <= 5'd0;
            left_r      <= 1'b0;
            sign_r      <= 1'b0;
            sov_r       <= 1'b0;
            exn_r       <= EXN_ZERO;
            r_r         <= {OUT_W{1'b0}};
            ovf_r       <= 1'b0;
            nan_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        sign_r     <= u_sign_s;
                        exn_r      <= u_exn_s;
                        mag_r      <= (u_exn_s == EXN_NORMAL) ? OUT_W'(u_mant_s) : {OUT_W{1'b0}};
                        cnt_r      <= u_shamt_s;
                        left_r     <= u_left_s;
                        sov_r      <= 1'b0;
                        in_ready_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (left_r) begin
                        sov_r <= sov_r | mag_r[OUT_W-1];
                        mag_r <= {mag_r[OUT_W-2:0], 1'b0};
                    end else begin
                        mag_r <= {1'b0, mag_r[OUT_W-1:1]};
                    end
                    cnt_r <= cnt_r - 5'd1;
                end
                ST_FIN: begin
                    r_r         <= fin_r_s;
                    ovf_r       <= fin_ovf_s;
                    nan_r       <= fin_nan_s;
                    out_valid_r <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign R         = r_r;
    assign ovf       = ovf_r;
    assign nan       = nan_r;

endmodule

// File: tb/tb_flopoco_fp_to_fix_4_4.sv
// Scoreboard bench for the FloPoCo 4/4 to fixed-point converter: an arithmetic
// reference model feeds a queue that is checked at each output handshake.
module tb_flopoco_fp_to_fix_4_4;

    typedef struct packed {
        logic [23:0] r;
        logic        ovf;
        logic        nan;
        logic [7:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, ovf, nan;
    logic        out_ready = 1'b1;
    logic [10:0] X;
    logic [15:0] R;

    logic        iv2, ir2, ov2, ovf2, nan2;
    logic        ordy2 = 1'b1;
    logic [10:0] x2;
    logic [11:0] r12;

    int   n_chk = 0, n_fail = 0, cyc = 0;
    int   acc_edge = 0, hs_edge = 0;
    bit   busy = 1'b0, prev_ov = 1'b0, b2b_chk = 1'b0;
    bit   rand_mode = 1'b0, rdy_fixed = 1'b1;
    exp_t q[$];

    flopoco_fp_to_fix_4_4 #(.OUT_W(16), .FRAC_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .X(X),
        .out_valid(out_valid), .out_ready(out_ready), .R(R), .ovf(ovf), .nan(nan)
    );

    flopoco_fp_to_fix_4_4 #(.OUT_W(12), .FRAC_W(4)) dut12 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .X(x2),
        .out_valid(ov2), .out_ready(ordy2), .R(r12), .ovf(ovf2), .nan(nan2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: value = (16+frac) * 2^(E-11+fw), truncated toward zero, then saturated.
    function automatic exp_t model(input logic [10:0] x, input int ow, input int fw);
        exp_t   e;
        longint m, v, lim, t;
        int     s;
        e     = '0;
        e.lat = 8'd2;
        s     = int'(x[7:4]) - 11 + fw;
        lim   = longint'(1) << (ow - 1);
        t     = 0;
        case (x[10:9])
            2'b00: t = 0;
            2'b11: e.nan = 1'b1;
            2'b10: begin
                t     = x[8] ? -lim : lim - 1;
                e.ovf = 1'b1;
            end
            default: begin
                m     = 16 + longint'(x[3:0]);
                v     = (s >= 0) ? (m << s) : (m >> (-s));
                e.lat = 8'((s < 0 ? -s : s) + 2);
                if (x[8] ? (v > lim) : (v > lim - 1)) begin
                    t     = x[8] ? -lim : lim - 1;
                    e.ovf = 1'b1;
                end else begin
                    t = x[8] ? -v : v;
                end
            end
        endcase
        e.r = 24'(t & ((longint'(1) << ow) - 1));
        return e;
    endfunction

    // Output monitor: latency inclusive of the accept edge, stable R, handshake pop.
    always @(negedge clk) begin
        if (reset) begin
            if (busy) check_eq("in_ready_busy", in_ready, 1'b0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check_eq("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    if (!prev_ov) check_eq("latency", cyc - acc_edge + 1, q[0].lat);
                    check_eq("R", R, q[0].r);
                    if (out_ready) begin
                        check_eq("ovf", ovf, q[0].ovf);
                        check_eq("nan", nan, q[0].nan);
                        void'(q.pop_front());
                        hs_edge = cyc + 1;
                        busy    = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                acc_edge = cyc + 1;
                busy     = 1'b1;
                if (b2b_chk) begin
                    check_eq("b2b_gap", acc_edge - hs_edge, 1);
                    b2b_chk = 1'b0;
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [10:0] x, input bit hold);
        bit ok;
        @(posedge clk); #1;
        in_valid = 1'b1;
        X        = x;
        q.push_back(model(x, 16, 4));
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        check_eq("drain", q.size(), 0);
    endtask

    initial begin
        exp_t e12;
        bit   got;
        reset    = 1'b0;
        in_valid = 1'b0;
        X        = 11'd0;
        iv2      = 1'b0;
        x2       = 11'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_R", R, 16'h0000);
        check_eq("rst_ovf", ovf, 1'b0);
        check_eq("rst_nan", nan, 1'b0);
        reset = 1'b1;

        send(11'b01010000000, 1'b0);   // 2.0
        send(11'b01010110000, 1'b1);   // 16.0, in_valid held
        b2b_chk = 1'b1;
        send(11'b01010100100, 1'b0);   // 10.0
        send(11'b01110001000, 1'b0);   // -3.0
        send(11'b01001111000, 1'b0);   // 1.5
        send(11'b01000000000, 1'b0);   // 2^-7
        send(11'b00101010101, 1'b0);   // zero
        send(11'b10000000000, 1'b0);   // +inf
        send(11'b10100000000, 1'b0);   // -inf
        send(11'b11000000000, 1'b0);   // NaN
        drain();

        rdy_fixed = 1'b0;
        send(11'b01010001000, 1'b0);   // 3.0 under backpressure
        repeat (12) @(posedge clk);
        #1;
        rdy_fixed = 1'b1;
        drain();

        send(11'b01010110000, 1'b0);   // 16.0, interrupted by reset
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 1'b0);
        check_eq("midrst_in_ready", in_ready, 1'b1);
        q.delete();
        busy    = 1'b0;
        prev_ov = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        send(11'b01010000000, 1'b0);
        drain();

        rand_mode = 1'b1;
        for (int i = 0; i < 25; i++) send(11'($urandom), 1'b0);
        drain();
        rand_mode = 1'b0;

        e12 = model(11'b01011111111, 12, 4);
        @(posedge clk); #1;
        iv2 = 1'b1;
        x2  = 11'b01011111111;
        @(posedge clk); #1;
        iv2 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ov2) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("w12_out_valid", got, 1'b1);
        check_eq("w12_R", r12, e12.r);
        check_eq("w12_ovf", ovf2, e12.ovf);
        check_eq("w12_nan", nan2, e12.nan);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
